proc_io_hub: RTL
================

// Module: proc_io_hub
// PURPOSE
//   Parametrised I/O hub between one proc_fx core and NUIOIN input / NUIOOU output channels.
//   Replaces the bare addr_dec strobe decoding with one FIFO per channel and valid/ready
//   handshakes on the channel side.
//   Adds a stall signal so the core holds while a read targets an empty FIFO or a write
//   targets a full one.
//   Sits in the processor wrapper between the core's io ports and the multicore fabric.
// PARAMETERS
//   NUBITS  32  data word width (matches core NUBITS)
//   NUIOIN  2   number of input channels (>=1)
//   NUIOOU  2   number of output channels (>=1)
//   FDEPTH  4   entries per channel FIFO; power of two, >=2
//   AWIN    derived: $clog2(NUIOIN) (min 1), width of proc_addr_in
//   AWOU    derived: $clog2(NUIOOU) (min 1), width of proc_addr_out
// PORTS
//   clk            in   1              single clock; all state on rising edge
//   rst            in   1              asynchronous reset, active-low
//   proc_req_in    in   1              core read strobe (one cycle per word)
//   proc_addr_in   in   AWIN           input channel selected for read
//   proc_io_in     out  NUBITS         head word of the selected input FIFO, to core
//   proc_out_en    in   1              core write strobe
//   proc_addr_out  in   AWOU           output channel selected for write
//   proc_io_out    in   NUBITS         word written by core
//   proc_stall     out  1              core must hold current instruction
//   ch_in_data     in   NUIOIN*NUBITS  channel k at bits [k*NUBITS +: NUBITS]
//   ch_in_valid    in   NUIOIN         per-channel push request
//   ch_in_ready    out  NUIOIN         per-channel not full
//   ch_out_data    out  NUIOOU*NUBITS  head word of each output FIFO
//   ch_out_valid   out  NUIOOU         per-channel not empty
//   ch_out_ready   in   NUIOOU         per-channel pop acknowledge
//   err_addr       out  1              sticky: access to a nonexistent channel
// BEHAVIOUR
//   - Reset (rst=0, async): all FIFOs empty, pointers and counts 0, err_addr=0.
//     Hence ch_in_ready all 1, ch_out_valid all 0, ch_out_data 0, proc_io_in 0.
//   - FIFO: rd/wr pointers wrap modulo FDEPTH. Count is 0..FDEPTH.
//     full = (count==FDEPTH), empty = (count==0), both from registered count.
//   - Channel push: when ch_in_valid[k] & ch_in_ready[k], the word is written at the edge.
//     ready is !full of the registered count; a same-cycle core pop never frees a slot early.
//   - Channel pop: when ch_out_valid[k] & ch_out_ready[k], the head advances at the edge.
//   - Read path: proc_io_in = head of FIFO[proc_addr_in], combinational; 0 when empty.
//     The FIFO pops at the edge when proc_req_in=1 and it is not stalled.
//   - Write path: with proc_out_en=1 and no stall, proc_io_out is pushed into FIFO[proc_addr_out].
//   - proc_stall is combinational:
//     (proc_req_in & empty[addr_in]) | (proc_out_en & full[addr_out]), for valid addresses only.
//     While stalled, no core-side push or pop happens; the channel side keeps operating.
//   - Stall on both strobes: if either side stalls, neither the read nor the write is performed.
//   - Simultaneous push and pop on one FIFO with 0<count<FDEPTH: both happen, count unchanged.
//   - Simultaneous push and pop on an empty FIFO: the pop is not allowed, the push happens,
//     count becomes 1.
//   - Simultaneous push and pop on a full FIFO: the pop happens; the push is blocked by ready/stall.
//   - Address >= NUIOIN on a read, or >= NUIOOU on a write:
//     no FIFO effect, proc_io_in=0, no stall, err_addr set to 1 until reset.
//   - Latency: channel word pushed at edge t is visible on proc_io_in from cycle t+1.
//     Core word written at edge t gives ch_out_valid=1 from cycle t+1.
//   - Reset mid-transfer discards all FIFO contents; there is no partial-word state.
// TESTING
//   1 Reset: hold rst=0 -> ch_in_ready=2'b11, ch_out_valid=0, proc_stall=0, err_addr=0.
//   2 Push 0x11,0x22 on ch_in 1, then req_in with addr_in=1 on two cycles
//     -> proc_io_in reads 0x11 then 0x22; ch_in_ready[1] stays 1.
//   3 req_in with addr_in=0 on an empty FIFO -> proc_stall=1 and proc_io_in=0.
//     Then push 0x5A on ch0 -> stall drops the next cycle and the core reads 0x5A.
//   4 Five writes to addr_out=1 with ch_out_ready=0 and FDEPTH=4 -> the fifth write stalls.
//     Raise ready -> the channel drains 4 words in order, the stalled write completes,
//     and 5 words arrive in total.
//   5 Push and core pop on ch0 in the same cycle at count=2 -> count stays 2 and order is kept.
//   6 With NUIOIN=3, read addr_in=3 -> err_addr=1 (sticky), no stall, and no FIFO changes.

Source files
------------

// File: rtl/proc_io_hub.sv
// I/O hub between one proc_fx core and NUIOIN input / NUIOOU output channels.
// Every channel owns a FIFO. The core stalls when it reads an empty FIFO or writes a full one.
module proc_io_hub #(
   parameter int NUBITS = 32,
   parameter int NUIOIN = 2,
   parameter int NUIOOU = 2,
   parameter int FDEPTH = 4,
   parameter int AWIN   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
   parameter int AWOU   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     proc_req_in,
   input  logic [AWIN-1:0]          proc_addr_in,
   output logic [NUBITS-1:0]        proc_io_in,
   input  logic                     proc_out_en,
   input  logic [AWOU-1:0]          proc_addr_out,
   input  logic [NUBITS-1:0]        proc_io_out,
   output logic                     proc_stall,
   input  logic [NUIOIN*NUBITS-1:0] ch_in_data,
   input  logic [NUIOIN-1:0]        ch_in_valid,
   output logic [NUIOIN-1:0]        ch_in_ready,
   output logic [NUIOOU*NUBITS-1:0] ch_out_data,
   output logic [NUIOOU-1:0]        ch_out_valid,
   input  logic [NUIOOU-1:0]        ch_out_ready,
   output logic                     err_addr
);

   localparam int PW = $clog2(FDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

   logic [NUIOIN-1:0][FDEPTH-1:0][NUBITS-1:0] in_mem_q, in_mem_d;
   logic [NUIOIN-1:0][PW-1:0]                 in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
   logic [NUIOIN-1:0][CW-1:0]                 in_cnt_q, in_cnt_d;
   logic [NUIOIN-1:0]                         in_empty, in_full, in_push, in_pop, rd_hit;

   logic [NUIOOU-1:0][FDEPTH-1:0][NUBITS-1:0] out_mem_q, out_mem_d;
   logic [NUIOOU-1:0][PW-1:0]                 out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
   logic [NUIOOU-1:0][CW-1:0]                 out_cnt_q, out_cnt_d;
   logic [NUIOOU-1:0]                         out_empty, out_full, out_push, out_pop, wr_hit;

   logic              err_addr_q, err_addr_d;
   logic              rd_valid, wr_valid, rd_stall, wr_stall, core_pop, core_push;
   logic [NUBITS-1:0] rd_head;

   // Status flags and address decode. An address with no hit is a nonexistent channel.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      in_empty = '0;
      in_full  = '0;
      rd_hit   = '0;
      for (int k = 0; k < NUIOIN; k++) begin
         in_empty[k] = (in_cnt_q[k] == '0);
         in_full[k]  = (in_cnt_q[k] == FULL_CNT);
         rd_hit[k]   = (proc_addr_in == AWIN'(k));
      end
      out_empty = '0;
      out_full  = '0;
      wr_hit    = '0;
      for (int k = 0; k < NUIOOU; k++) begin
         out_empty[k] = (out_cnt_q[k] == '0);
         out_full[k]  = (out_cnt_q[k] == FULL_CNT);
         wr_hit[k]    = (proc_addr_out == AWOU'(k));
      end
   end

   always_comb begin
      rd_valid = |rd_hit;
      wr_valid = |wr_hit;
      rd_stall = 1'b0;
      wr_stall = 1'b0;
      rd_head  = '0;
      for (int k = 0; k < NUIOIN; k++) begin
         if (rd_hit[k]) begin
            rd_stall = proc_req_in & in_empty[k];
            if (!in_empty[k]) rd_head = in_mem_q[k][in_rptr_q[k]];
         end
      end
      for (int k = 0; k < NUIOOU; k++) begin
         if (wr_hit[k]) wr_stall = proc_out_en & out_full[k];
      end
      // A stall on either side blocks both core strobes.
      proc_stall = rd_stall | wr_stall;
      core_pop   = proc_req_in & rd_valid & ~proc_stall;
      core_push  = proc_out_en & wr_valid & ~proc_stall;
   end

   // Input FIFOs: the channel pushes and the core pops. A core pop never targets an
   // empty FIFO, because the stall blocks it.
   always_comb begin
      in_mem_d  = in_mem_q;
      in_wptr_d = in_wptr_q;
      in_rptr_d = in_rptr_q;
      in_cnt_d  = in_cnt_q;
      in_push   = '0;
      in_pop    = '0;
      for (int k = 0; k < NUIOIN; k++) begin
         in_push[k] = ch_in_valid[k] & ~in_full[k];
         in_pop[k]  = core_pop & rd_hit[k];
         if (in_push[k]) begin
            in_mem_d[k][in_wptr_q[k]] = ch_in_data[k*NUBITS +: NUBITS];
            in_wptr_d[k] = in_wptr_q[k] + PW'(1);
         end
         if (in_pop[k]) in_rptr_d[k] = in_rptr_q[k] + PW'(1);
         in_cnt_d[k] = in_cnt_q[k] + CW'(in_push[k]) - CW'(in_pop[k]);
      end
   end

   // Output FIFOs: the core pushes and the channel pops.
   always_comb begin
      out_mem_d  = out_mem_q;
      out_wptr_d = out_wptr_q;
      out_rptr_d = out_rptr_q;
      out_cnt_d  = out_cnt_q;
      out_push   = '0;
      out_pop    = '0;
      for (int k = 0; k < NUIOOU; k++) begin
         out_push[k] = core_push & wr_hit[k];
         out_pop[k]  = ch_out_ready[k] & ~out_empty[k];
         if (out_push[k]) begin
            out_mem_d[k][out_wptr_q[k]] = proc_io_out;
            out_wptr_d[k] = out_wptr_q[k] + PW'(1);
         end
         if (out_pop[k]) out_rptr_d[k] = out_rptr_q[k] + PW'(1);
         out_cnt_d[k] = out_cnt_q[k] + CW'(out_push[k]) - CW'(out_pop[k]);
      end
   end

   assign err_addr_d = err_addr_q | (proc_req_in & ~rd_valid) | (proc_out_en & ~wr_valid);

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_wptr_q  <= '0;
         in_rptr_q  <= '0;
         in_cnt_q   <= '0;
         out_wptr_q <= '0;
         out_rptr_q <= '0;
         out_cnt_q  <= '0;
         err_addr_q <= 1'b0;
      end else begin
         in_wptr_q  <= in_wptr_d;
         in_rptr_q  <= in_rptr_d;
         in_cnt_q   <= in_cnt_d;
         out_wptr_q <= out_wptr_d;
         out_rptr_q <= out_rptr_d;
         out_cnt_q  <= out_cnt_d;
         err_addr_q <= err_addr_d;
      end
   end

   // NOTE: the FIFO storage is not reset. Every read of storage is gated by a nonzero count,
   // so stale contents are never visible, and the storage can map to plain RAM.
   always_ff @(posedge clk) begin
      in_mem_q  <= in_mem_d;
      out_mem_q <= out_mem_d;
   end

   always_comb begin
      ch_out_data = '0;
      for (int k = 0; k < NUIOOU; k++) begin
         if (!out_empty[k]) ch_out_data[k*NUBITS +: NUBITS] = out_mem_q[k][out_rptr_q[k]];
      end
   end

   assign proc_io_in   = rd_head;
   assign ch_in_ready  = ~in_full;
   assign ch_out_valid = ~out_empty;
   assign err_addr     = err_addr_q;

endmodule
